ex_muldiv_sequencer: RTL

- Multi-cycle controller and iterative datapath for RV32M multiply/divide ops issued into the execute stage.
- Accepts one operation from decode and asserts `stall` to freeze the pipeline while it iterates.
- Presents a one-cycle `result_valid` pulse with the result, which the execute stage muxes onto `alu_data`.
- Handles divide-by-zero and signed overflow on a fast path.

---
 rtl/ex_muldiv_sequencer_if.sv | 25 ++
 rtl/ex_muldiv_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer_if.sv
// Issue/result handshake between the execute stage and the RV32M multiply/divide sequencer.
// The master side is the decode/execute pipeline; the slave side is the sequencer.
interface ex_muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            issue_valid;
    logic [2:0]      issue_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output issue_valid, issue_op, operand_a, operand_b, flush,
        input  stall, busy, result_valid, result
    );

    modport slave (
        input  issue_valid, issue_op, operand_a, operand_b, flush,
        output stall, busy, result_valid, result
    );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign correction on the final step.
module ex_muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ex_muldiv_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL = 3'b000;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   d_q, d_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0]   final_res;

    // funct3[2] selects divide; operand signedness follows the RV32M op table
    assign is_div = op_q[2];
    assign a_sgn  = is_div ? ~op_q[0] : (op_q != 3'b011);
    assign b_sgn  = is_div ? ~op_q[0] : ~op_q[1];
    assign a_neg  = a_sgn & a_q[XLEN-1];
    assign b_neg  = b_sgn & b_q[XLEN-1];
    assign a_mag  = neg_if(a_q, a_neg);
    assign b_mag  = neg_if(b_q, b_neg);

    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = is_div && !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, d_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, d_q};
        rem_ge   = ~rem_diff[XLEN];
        if (is_div) begin
            step = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
        end else begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = neg_if_wide(step, neg_q);
        if (is_div) begin
            final_res = neg_if(op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0], neg_q);
        end else begin
            final_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.issue_valid) begin
                    op_d    = bus.issue_op;
                    a_d     = bus.operand_a;
                    b_d     = bus.operand_b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (div_zero) begin
                    result_d = op_q[1] ? a_q : '1;
                    state_d  = S_DONE;
                end else if (div_ovf) begin
                    result_d = op_q[1] ? '0 : a_q;
                    state_d  = S_DONE;
                end else begin
                    // d_q holds the multiplicand or divisor; acc_q low half the multiplier or dividend
                    d_d     = is_div ? b_mag : a_mag;
                    acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                    neg_d   = (is_div && op_q[1]) ? a_neg : (a_neg ^ b_neg);
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A flush abandons whatever is in flight and never touches the result
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.stall        = ((state_q == S_IDLE) && bus.issue_valid && !bus.flush)
                              || (state_q == S_PREP) || (state_q == S_ITER);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = (state_q == S_DONE) && !bus.flush;
    assign bus.result       = result_q;
endmodule
